// File: rtl/ssp_uart_host_master_if.sv
// Command/response port and SSP register-access bus of the SSP UART host master.
// The master modport is the initiator (host) view; slave is the opposite side.
interface ssp_uart_host_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wnr;
  logic [2:0]  cmd_ra;
  logic [11:0] cmd_wdata;
  logic        rsp_valid;
  logic [11:0] rsp_rdata;
  logic        busy;
  logic        SSP_SSEL;
  logic        SSP_SCK;
  logic [2:0]  SSP_RA;
  logic        SSP_WnR;
  logic        SSP_En;
  logic        SSP_EOC;
  logic [11:0] SSP_DI;
  logic [11:0] SSP_DO;

  modport master (
    input  cmd_valid, cmd_wnr, cmd_ra, cmd_wdata, SSP_DO,
    output cmd_ready, rsp_valid, rsp_rdata, busy,
    output SSP_SSEL, SSP_SCK, SSP_RA, SSP_WnR, SSP_En, SSP_EOC, SSP_DI
  );

  modport slave (
    output cmd_valid, cmd_wnr, cmd_ra, cmd_wdata, SSP_DO,
    input  cmd_ready, rsp_valid, rsp_rdata, busy,
    input  SSP_SSEL, SSP_SCK, SSP_RA, SSP_WnR, SSP_En, SSP_EOC, SSP_DI
  );
endinterface

// File: rtl/ssp_uart_host_master.sv
// SSP initiator for the UART register port: one 16-SCK-period frame per accepted
// command (4 header periods, 12 data periods), then an idle gap before the next.
module ssp_uart_host_master #(
  parameter int SCK_DIV = 2,
  parameter int GAP     = 4
) (
  input logic                    Clk,
  input logic                    Rst,
  ssp_uart_host_master_if.master bus
);

  localparam int DIV_W = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? (GAP - 1) : 0);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_DATA, ST_GAP} state_t;

  state_t             state_r;
  logic [DIV_W-1:0]   div_cnt_r;
  logic [3:0]         per_r;
  logic [GAP_W-1:0]   gap_cnt_r;
  logic [11:0]        cap_r;
  logic               cmd_ready_r;
  logic               rsp_valid_r;
  logic [11:0]        rsp_rdata_r;
  logic               busy_r;
  logic               ssel_r;
  logic               sck_r;
  logic [2:0]         ra_r;
  logic               wnr_r;
  logic               en_r;
  logic               eoc_r;
  logic [11:0]        di_r;

  // Frame sequencer: SCK divider, period counter, bus outputs and response.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_r     <= ST_IDLE;
      div_cnt_r   <= {DIV_W{1'b0}};
      per_r       <= 4'd0;
      gap_cnt_r   <= {GAP_W{1'b0}};
      cap_r       <= 12'd0;
      cmd_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 12'd0;
      busy_r      <= 1'b0;
      ssel_r      <= 1'b0;
      sck_r       <= 1'b0;
      ra_r        <= 3'd0;
      wnr_r       <= 1'b0;
      en_r        <= 1'b0;
      eoc_r       <= 1'b0;
      di_r        <= 12'd0;
    end else begin
      rsp_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.cmd_valid && cmd_ready_r) begin
            state_r     <= ST_HDR;
            cmd_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            ssel_r      <= 1'b1;
            sck_r       <= 1'b0;
            ra_r        <= bus.cmd_ra;
            wnr_r       <= bus.cmd_wnr;
            di_r        <= bus.cmd_wnr ? bus.cmd_wdata : 12'd0;
            en_r        <= 1'b0;
            eoc_r       <= 1'b0;
            div_cnt_r   <= {DIV_W{1'b0}};
            per_r       <= 4'd0;
            cap_r       <= 12'd0;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_HDR, ST_DATA: begin
          if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= {DIV_W{1'b0}};
            sck_r     <= ~sck_r;
            if (!sck_r) begin
              // Slave samples on this rising edge; read data is valid during EOC.
              if (eoc_r) begin
                cap_r <= bus.SSP_DO;
              end else begin
                cap_r <= cap_r;
              end
            end else if (per_r == 4'd15) begin
              ssel_r      <= 1'b0;
              en_r        <= 1'b0;
              eoc_r       <= 1'b0;
              ra_r        <= 3'd0;
              wnr_r       <= 1'b0;
              di_r        <= 12'd0;
              rsp_valid_r <= 1'b1;
              rsp_rdata_r <= wnr_r ? 12'd0 : cap_r;
              per_r       <= 4'd0;
              gap_cnt_r   <= {GAP_W{1'b0}};
              if (GAP == 0) begin
                state_r     <= ST_IDLE;
                busy_r      <= 1'b0;
                cmd_ready_r <= 1'b1;
              end else begin
                state_r <= ST_GAP;
              end
            end else begin
              per_r <= per_r + 4'd1;
              if (per_r == 4'd3) begin
                en_r    <= 1'b1;
                state_r <= ST_DATA;
              end else begin
                state_r <= state_r;
              end
              if (per_r == 4'd14) begin
                eoc_r <= 1'b1;
              end else begin
                eoc_r <= eoc_r;
              end
            end
          end else begin
            div_cnt_r <= div_cnt_r + DIV_ONE;
          end
        end
        ST_GAP: begin
          if (gap_cnt_r == GAP_LAST) begin
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            cmd_ready_r <= 1'b1;
            gap_cnt_r   <= {GAP_W{1'b0}};
          end else begin
            gap_cnt_r <= gap_cnt_r + GAP_ONE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          busy_r      <= 1'b0;
          cmd_ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_rdata = rsp_rdata_r;
  assign bus.busy      = busy_r;
  assign bus.SSP_SSEL  = ssel_r;
  assign bus.SSP_SCK   = sck_r;
  assign bus.SSP_RA    = ra_r;
  assign bus.SSP_WnR   = wnr_r;
  assign bus.SSP_En    = en_r;
  assign bus.SSP_EOC   = eoc_r;
  assign bus.SSP_DI    = di_r;

endmodule
